// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD 24-hour clock with NUM_ALARMS alarm slots,
// snooze and ring auto-timeout.
module multi_alarm_clock #(
  parameter int TICK_DIV       = 100_000_000,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       hour_in1,
  input  logic [3:0]       hour_in0,
  input  logic [3:0]       minute_in1,
  input  logic [3:0]       minute_in0,
  input  logic             load_time,
  input  logic             load_alarm,
  input  logic [SEL_W-1:0] alarm_sel,
  input  logic             alarm_en_wr,
  input  logic             alarm_en_in,
  input  logic             STOP_alarm,
  input  logic             snooze,
  output logic             Alarm,
  output logic [SEL_W-1:0] alarm_src,
  output logic             snoozed,
  output logic             load_err,
  output logic             tick,
  output logic [1:0]       hour_out1,
  output logic [3:0]       hour_out0,
  output logic [3:0]       minute_out1,
  output logic [3:0]       minute_out0,
  output logic [5:0]       seconds
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int SNZ = SNOOZE_MIN * 60;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNZ
  } state_t;

  logic [PW-1:0]   r_presc;
  logic [1:0]      r_h1;
  logic [3:0]      r_h0;
  logic [3:0]      r_m1;
  logic [3:0]      r_m0;
  logic [5:0]      r_sec;
  logic            r_rolled;
  logic            r_load_err;
  logic [1:0]      r_al_h1 [NUM_ALARMS];
  logic [3:0]      r_al_h0 [NUM_ALARMS];
  logic [3:0]      r_al_m1 [NUM_ALARMS];
  logic [3:0]      r_al_m0 [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_al_en;
  state_t          r_state;
  logic            r_alarm;
  logic            r_snoozed;
  logic [SEL_W-1:0] r_src;
  logic [7:0]      r_ring_cnt;
  logic [11:0]     r_snz_cnt;

  logic            w_tick;
  logic            w_hr_ok;
  logic            w_valid;
  logic            w_ld_time;
  logic            w_hit;
  logic [SEL_W-1:0] w_idx;
  logic            w_match;

  assign w_tick    = (r_presc == PW'(TICK_DIV - 1));
  assign w_hr_ok   = (hour_in1 < 2'd2) ? (hour_in0 <= 4'd9) :
                     (hour_in1 == 2'd2) && (hour_in0 <= 4'd3);
  assign w_valid   = w_hr_ok && (minute_in1 <= 4'd5) &&
                     (minute_in0 <= 4'd9);
  assign w_ld_time = load_time && w_valid;

  // Prescaler: one-cycle tick every TICK_DIV cycles, restarted by a time load
  always_ff @(posedge clock) begin
    if (reset || w_ld_time || w_tick) r_presc <= '0;
    else r_presc <= r_presc + 1'b1;
  end

  // Time of day: load wins over tick; tick carries through BCD digits
  always_ff @(posedge clock) begin
    if (reset) begin
      r_h1     <= '0;
      r_h0     <= '0;
      r_m1     <= '0;
      r_m0     <= '0;
      r_sec    <= '0;
      r_rolled <= 1'b0;
    end else if (w_ld_time) begin
      r_h1     <= hour_in1;
      r_h0     <= hour_in0;
      r_m1     <= minute_in1;
      r_m0     <= minute_in0;
      r_sec    <= '0;
      r_rolled <= 1'b0;
    end else if (w_tick) begin
      r_rolled <= (r_sec == 6'd59);
      if (r_sec != 6'd59) begin
        r_sec <= r_sec + 6'd1;
      end else begin
        r_sec <= '0;
        if (r_m0 != 4'd9) begin
          r_m0 <= r_m0 + 4'd1;
        end else begin
          r_m0 <= '0;
          if (r_m1 != 4'd5) begin
            r_m1 <= r_m1 + 4'd1;
          end else begin
            r_m1 <= '0;
            if (r_h1 == 2'd2 && r_h0 == 4'd3) begin
              r_h1 <= '0;
              r_h0 <= '0;
            end else if (r_h0 == 4'd9) begin
              r_h0 <= '0;
              r_h1 <= r_h1 + 2'd1;
            end else begin
              r_h0 <= r_h0 + 4'd1;
            end
          end
        end
      end
    end else begin
      r_rolled <= 1'b0;
    end
  end

  // Rejected loads raise a single-cycle error pulse
  always_ff @(posedge clock) begin
    if (reset) r_load_err <= 1'b0;
    else r_load_err <= (load_time || load_alarm) && !w_valid;
  end

  // Alarm slot storage and enable bits
  always_ff @(posedge clock) begin
    if (reset) begin
      r_al_en <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_al_h1[i] <= '0;
        r_al_h0[i] <= '0;
        r_al_m1[i] <= '0;
        r_al_m0[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_sel == SEL_W'(i)) begin
          if (load_alarm && w_valid) begin
            r_al_h1[i] <= hour_in1;
            r_al_h0[i] <= hour_in0;
            r_al_m1[i] <= minute_in1;
            r_al_m0[i] <= minute_in0;
          end
          if (alarm_en_wr) r_al_en[i] <= alarm_en_in;
        end
      end
    end
  end

  // Lowest enabled slot equal to hh:mm, only right after seconds roll to 0
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_al_en[i] && r_al_h1[i] == r_h1 && r_al_h0[i] == r_h0 &&
          r_al_m1[i] == r_m1 && r_al_m0[i] == r_m0) begin
        w_hit = 1'b1;
        w_idx = SEL_W'(i);
      end
    end
    w_match = w_hit && r_rolled;
  end

  // Ring/snooze state machine with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_alarm    <= 1'b0;
      r_snoozed  <= 1'b0;
      r_src      <= '0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!STOP_alarm && w_match) begin
            r_state    <= S_RING;
            r_alarm    <= 1'b1;
            r_src      <= w_idx;
            r_ring_cnt <= '0;
          end
        end
        S_RING: begin
          if (STOP_alarm) begin
            r_state <= S_IDLE;
            r_alarm <= 1'b0;
          end else if (snooze) begin
            r_state   <= S_SNZ;
            r_alarm   <= 1'b0;
            r_snoozed <= 1'b1;
            r_snz_cnt <= 12'(SNZ);
          end else if (w_tick) begin
            if (r_ring_cnt == 8'(RING_TIMEOUT_S - 1)) begin
              r_state <= S_IDLE;
              r_alarm <= 1'b0;
            end else begin
              r_ring_cnt <= r_ring_cnt + 8'd1;
            end
          end
        end
        S_SNZ: begin
          if (STOP_alarm) begin
            r_state   <= S_IDLE;
            r_snoozed <= 1'b0;
          end else if (w_tick) begin
            if (r_snz_cnt <= 12'd1) begin
              r_state    <= S_RING;
              r_alarm    <= 1'b1;
              r_snoozed  <= 1'b0;
              r_ring_cnt <= '0;
            end else begin
              r_snz_cnt <= r_snz_cnt - 12'd1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_alarm   <= 1'b0;
          r_snoozed <= 1'b0;
        end
      endcase
    end
  end

  assign Alarm       = r_alarm;
  assign alarm_src   = r_src;
  assign snoozed     = r_snoozed;
  assign load_err    = r_load_err;
  assign tick        = w_tick;
  assign hour_out1   = r_h1;
  assign hour_out0   = r_h0;
  assign minute_out1 = r_m1;
  assign minute_out0 = r_m0;
  assign seconds     = r_sec;

endmodule
